// File: rtl/alu_muldiv_if.sv
// Request/result bundle between the microcode sequencer (master) and the
// iterative multiply/divide unit (slave).
interface alu_muldiv_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic             is_8_bit;
    logic [WIDTH-1:0] a_lo;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out_lo;
    logic [WIDTH-1:0] out_hi;
    logic             cf_of;
    logic             div_error;

    modport master (
        output start, op, is_8_bit, a_lo, a_hi, b,
        input  busy, done, out_lo, out_hi, cf_of, div_error
    );

    modport slave (
        input  start, op, is_8_bit, a_lo, a_hi, b,
        output busy, done, out_lo, out_hi, cf_of, div_error
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative MUL/IMUL/DIV/IDIV unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, for full (WIDTH) and half (WIDTH/2) operand sizes.
module alu_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    alu_muldiv_if.slave bus
);
    localparam int H  = WIDTH / 2;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]        LAST_FULL = CW'(WIDTH - 1);
    localparam logic [CW-1:0]        LAST_HALF = CW'(H - 1);
    localparam logic [CW-1:0]        CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]     ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0]   ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]     LIM_FULL  = ONE_W << (WIDTH - 1);
    localparam logic [WIDTH-1:0]     LIM_HALF  = ONE_W << (H - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_ERR  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t               state_r;
    logic [1:0]           op_r;
    logic                 half_r;
    logic [WIDTH-1:0]     a_lo_r, a_hi_r, b_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     rem_r, q_r, d_r;
    logic [CW-1:0]        cnt_r;
    logic                 q_neg_r, r_neg_r, ovf_r;
    logic                 busy_r, done_r, cf_of_r, div_error_r;
    logic [WIDTH-1:0]     out_lo_r, out_hi_r;

    logic                 sgn_s, is_div_s;
    logic [WIDTH-1:0]     a_ext_s, b_ext_s, a_mag_s, b_mag_s, mplr_s;
    logic                 a_neg_s, b_neg_s, dvd_neg_s;
    logic [2*WIDTH-1:0]   dvd_s, dvd_mag_s;
    logic [WIDTH-1:0]     dvd_hi_s, dvd_lo_s;
    logic                 prep_err_s;
    logic [WIDTH:0]       shl_s;
    logic                 fits_s;
    logic [WIDTH-1:0]     sub_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quo_s, rmd_s, lim_s;
    logic                 q_ovf_s, cf_s;
    logic [WIDTH-1:0]     res_lo_s, res_hi_s;

    // Widen an N-bit field to WIDTH bits, sign- or zero-filling in half mode.
    function automatic logic [WIDTH-1:0] ext_n(input logic [WIDTH-1:0] v,
                                               input logic half,
                                               input logic sgn);
        logic [WIDTH-1:0] r;
        if (half) begin
            r = {{H{sgn & v[H-1]}}, v[H-1:0]};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Magnitude of a WIDTH-bit value that is two's complement when sgn is set.
    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v,
                                               input logic sgn);
        logic [WIDTH-1:0] r;
        if (sgn && v[WIDTH-1]) begin
            r = ~v + ONE_W;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Operand conditioning used in PREP: magnitudes, signs and bit alignment.
    always_comb begin
        sgn_s     = op_r[0];
        is_div_s  = op_r[1];
        a_ext_s   = ext_n(a_lo_r, half_r, sgn_s);
        b_ext_s   = ext_n(b_r, half_r, sgn_s);
        a_neg_s   = sgn_s & a_ext_s[WIDTH-1];
        b_neg_s   = sgn_s & b_ext_s[WIDTH-1];
        a_mag_s   = mag_w(a_ext_s, sgn_s);
        b_mag_s   = mag_w(b_ext_s, sgn_s);
        dvd_s     = half_r ? {{WIDTH{sgn_s & a_lo_r[WIDTH-1]}}, a_lo_r} : {a_hi_r, a_lo_r};
        dvd_neg_s = sgn_s & dvd_s[2*WIDTH-1];
        dvd_mag_s = dvd_neg_s ? (~dvd_s + ONE_2W) : dvd_s;
        // Half-mode low halves sit at the top so both sizes shift out of bit WIDTH-1.
        if (half_r) begin
            dvd_hi_s = {{H{1'b0}}, dvd_mag_s[WIDTH-1:H]};
            dvd_lo_s = {dvd_mag_s[H-1:0], {H{1'b0}}};
            mplr_s   = {b_mag_s[H-1:0], {H{1'b0}}};
        end else begin
            dvd_hi_s = dvd_mag_s[2*WIDTH-1:WIDTH];
            dvd_lo_s = dvd_mag_s[WIDTH-1:0];
            mplr_s   = b_mag_s;
        end
        prep_err_s = is_div_s && ((b_mag_s == {WIDTH{1'b0}}) || (!sgn_s && (dvd_hi_s >= b_mag_s)));
    end

    // Per-bit divide step and sign fix-up / result packing for FIX.
    always_comb begin
        shl_s   = {rem_r, q_r[WIDTH-1]};
        fits_s  = shl_s >= {1'b0, d_r};
        sub_s   = shl_s[WIDTH-1:0] - d_r;
        prod_s  = q_neg_r ? (~acc_r + ONE_2W) : acc_r;
        quo_s   = q_neg_r ? (~q_r + ONE_W) : q_r;
        rmd_s   = r_neg_r ? (~rem_r + ONE_W) : rem_r;
        lim_s   = half_r ? LIM_HALF : LIM_FULL;
        q_ovf_s = ovf_r || (q_neg_r ? (q_r > lim_s) : (q_r >= lim_s));
        cf_s    = 1'b0;
        if (half_r) begin
            if (sgn_s) begin
                cf_s = prod_s[WIDTH-1:H] != {H{prod_s[H-1]}};
            end else begin
                cf_s = prod_s[WIDTH-1:H] != {H{1'b0}};
            end
        end else begin
            if (sgn_s) begin
                cf_s = prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};
            end else begin
                cf_s = prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}};
            end
        end
        res_lo_s = {WIDTH{1'b0}};
        res_hi_s = {WIDTH{1'b0}};
        if (is_div_s) begin
            if (half_r) begin
                res_lo_s = {rmd_s[H-1:0], quo_s[H-1:0]};
            end else begin
                res_lo_s = quo_s;
                res_hi_s = rmd_s;
            end
        end else begin
            res_lo_s = prod_s[WIDTH-1:0];
            if (half_r) begin
                res_hi_s = {WIDTH{1'b0}};
            end else begin
                res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            end
        end
    end

    // Control FSM, iteration datapath and registered result/flag outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            op_r        <= 2'b00;
            half_r      <= 1'b0;
            a_lo_r      <= {WIDTH{1'b0}};
            a_hi_r      <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            acc_r       <= {(2*WIDTH){1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            q_r         <= {WIDTH{1'b0}};
            d_r         <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            ovf_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cf_of_r     <= 1'b0;
            div_error_r <= 1'b0;
            out_lo_r    <= {WIDTH{1'b0}};
            out_hi_r    <= {WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE, S_ERR, S_DONE: begin
                    if (bus.start) begin
                        op_r        <= bus.op;
                        half_r      <= bus.is_8_bit;
                        a_lo_r      <= bus.a_lo;
                        a_hi_r      <= bus.a_hi;
                        b_r         <= bus.b;
                        cf_of_r     <= 1'b0;
                        div_error_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= S_PREP;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_PREP: begin
                    cnt_r <= {CW{1'b0}};
                    acc_r <= {(2*WIDTH){1'b0}};
                    ovf_r <= dvd_hi_s >= b_mag_s;
                    if (is_div_s) begin
                        d_r     <= b_mag_s;
                        rem_r   <= dvd_hi_s;
                        q_r     <= dvd_lo_s;
                        q_neg_r <= dvd_neg_s ^ b_neg_s;
                        r_neg_r <= dvd_neg_s;
                    end else begin
                        d_r     <= a_mag_s;
                        rem_r   <= {WIDTH{1'b0}};
                        q_r     <= mplr_s;
                        q_neg_r <= a_neg_s ^ b_neg_s;
                        r_neg_r <= 1'b0;
                    end
                    if (prep_err_s) begin
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        div_error_r <= 1'b1;
                        state_r     <= S_ERR;
                    end else begin
                        state_r <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (is_div_s) begin
                        rem_r <= fits_s ? sub_s : shl_s[WIDTH-1:0];
                        q_r   <= {q_r[WIDTH-2:0], fits_s};
                    end else begin
                        acc_r <= {acc_r[2*WIDTH-2:0], 1'b0}
                               + (q_r[WIDTH-1] ? {{WIDTH{1'b0}}, d_r} : {(2*WIDTH){1'b0}});
                        q_r   <= {q_r[WIDTH-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == (half_r ? LAST_HALF : LAST_FULL)) begin
                        state_r <= S_FIX;
                    end else begin
                        state_r <= S_ITER;
                    end
                end
                S_FIX: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    if (is_div_s && sgn_s && q_ovf_s) begin
                        div_error_r <= 1'b1;
                        state_r     <= S_ERR;
                    end else begin
                        out_lo_r <= res_lo_s;
                        out_hi_r <= res_hi_s;
                        cf_of_r  <= is_div_s ? 1'b0 : cf_s;
                        state_r  <= S_DONE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.out_lo    = out_lo_r;
    assign bus.out_hi    = out_hi_r;
    assign bus.cf_of     = cf_of_r;
    assign bus.div_error = div_error_r;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv with hand-computed expectations.
module tb_alu_muldiv;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc;
    logic busy_c1;

    alu_muldiv_if #(.WIDTH(16)) bus ();

    alu_muldiv #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request (start sampled at edge 0) and wait for done; cyc is the
    // cycle in which done was seen. poke_at>0 pulses a stray start in that cycle.
    task automatic run_op(input logic [1:0] op_i, input logic half_i,
                          input logic [15:0] alo, input logic [15:0] ahi,
                          input logic [15:0] bb, input int poke_at);
        bus.op       = op_i;
        bus.is_8_bit = half_i;
        bus.a_lo     = alo;
        bus.a_hi     = ahi;
        bus.b        = bb;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc       = 1;
        busy_c1   = bus.busy;
        while (!bus.done && cyc < 40) begin
            if (cyc == poke_at) begin
                bus.start = 1'b1;
                bus.op    = 2'd2;
                bus.b     = 16'h0000;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int dones;
        bus.start    = 1'b0;
        bus.op       = 2'd0;
        bus.is_8_bit = 1'b0;
        bus.a_lo     = 16'h0000;
        bus.a_hi     = 16'h0000;
        bus.b        = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outs", {bus.busy, bus.done, bus.cf_of, bus.div_error, bus.out_hi, bus.out_lo},
                 64'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op(2'd0, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 0);
        check_eq("mul16_busy1", busy_c1, 1);
        check_eq("mul16_cyc", cyc, 19);
        check_eq("mul16_res", {bus.out_hi, bus.out_lo}, 32'hFFFE_0001);
        check_eq("mul16_cf", {bus.cf_of, bus.div_error}, 2'b10);

        run_op(2'd1, 1'b1, 16'h00FE, 16'h0000, 16'h0003, 0);
        check_eq("imul8_cyc", cyc, 11);
        check_eq("imul8_res", {bus.out_hi, bus.out_lo}, 32'h0000_FFFA);
        check_eq("imul8_cf", bus.cf_of, 0);

        run_op(2'd0, 1'b1, 16'hABFF, 16'h1234, 16'h12FF, 0);
        check_eq("mul8_res", {bus.out_hi, bus.out_lo}, 32'h0000_FE01);
        check_eq("mul8_cf", bus.cf_of, 1);

        run_op(2'd3, 1'b1, 16'hFFF9, 16'h0000, 16'h0002, 0);
        check_eq("idiv8_cyc", cyc, 11);
        check_eq("idiv8_res", {bus.out_hi, bus.out_lo}, 32'h0000_FFFD);
        check_eq("idiv8_flags", {bus.cf_of, bus.div_error}, 2'b00);

        run_op(2'd3, 1'b0, 16'h0064, 16'h0000, 16'hFFF9, 0);
        check_eq("idiv16_res", {bus.out_hi, bus.out_lo}, 32'h0002_FFF2);

        run_op(2'd3, 1'b1, 16'hFF80, 16'h0000, 16'h0001, 0);
        check_eq("idiv8_min_res", {bus.div_error, bus.out_hi, bus.out_lo}, 33'h0_0000_0080);

        run_op(2'd3, 1'b1, 16'h0080, 16'h0000, 16'h0001, 0);
        check_eq("idiv8_pos_ovf", {bus.div_error, bus.out_lo}, 17'h1_0080);
        check_eq("idiv8_pos_ovf_cyc", cyc, 11);

        run_op(2'd2, 1'b0, 16'h0000, 16'h0001, 16'h0002, 0);
        check_eq("div16_cyc", cyc, 19);
        check_eq("div16_res", {bus.div_error, bus.out_hi, bus.out_lo}, 33'h0_0000_8000);

        run_op(2'd2, 1'b0, 16'h0005, 16'h0000, 16'h0000, 0);
        check_eq("div0_cyc", cyc, 2);
        check_eq("div0_err", {bus.div_error, bus.out_hi, bus.out_lo}, 33'h1_0000_8000);

        run_op(2'd2, 1'b0, 16'h0000, 16'h0002, 16'h0002, 0);
        check_eq("divovf_cyc", cyc, 2);
        check_eq("divovf_err", {bus.div_error, bus.out_lo}, 17'h1_8000);

        run_op(2'd3, 1'b1, 16'h0100, 16'h0000, 16'h0001, 0);
        check_eq("idivovf_cyc", cyc, 11);
        check_eq("idivovf_err", {bus.div_error, bus.out_lo}, 17'h1_8000);

        // Issued in the done cycle of the previous error.
        run_op(2'd1, 1'b0, 16'hFFFF, 16'h0000, 16'h0002, 0);
        check_eq("b2b_cyc", cyc, 19);
        check_eq("b2b_res", {bus.div_error, bus.cf_of, bus.out_hi, bus.out_lo}, 34'h0_FFFF_FFFE);

        run_op(2'd0, 1'b0, 16'h1234, 16'h0000, 16'h0010, 5);
        check_eq("poke_cyc", cyc, 19);
        check_eq("poke_res", {bus.div_error, bus.cf_of, bus.out_hi, bus.out_lo}, 34'h1_0001_2340);
        @(posedge clk);
        #1;
        check_eq("poke_idle", {bus.busy, bus.done}, 2'b00);

        // Reset in cycle 5 of a 16-bit MUL.
        bus.op    = 2'd0;
        bus.is_8_bit = 1'b0;
        bus.a_lo  = 16'hFFFF;
        bus.b     = 16'hFFFF;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_busy_before", bus.busy, 1);
        reset = 1'b1;
        #1;
        check_eq("rst_mid_outs", {bus.busy, bus.done, bus.cf_of, bus.div_error, bus.out_hi, bus.out_lo},
                 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check_eq("rst_no_done", dones, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
